// File: rtl/girl_sprite_ctrl.sv
// Girl sprite controller: pixel hit test, ROM addressing, frame_clk-stepped walk FSM and registered colour output.
// Optional feature macro: GIRL_MIRROR_EN (mirror the idle sprite while facing left).
module girl_sprite_ctrl #(
  parameter int          SPRITE_W    = 20,
  parameter int          SPRITE_H    = 40,
  parameter int          ANIM_PERIOD = 8,
  parameter logic [23:0] TRANSPARENT = 24'hFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  girl_x,
  input  logic [9:0]  girl_y,
  input  logic        move_left,
  input  logic        move_right,
  input  logic [23:0] color_idle,
  input  logic [23:0] color_m1a,
  input  logic [23:0] color_m1b,
  input  logic [23:0] color_m2a,
  input  logic [23:0] color_m2b,
  output logic [10:0] rom_address,
  output logic [2:0]  frame_sel,
  output logic        girl_pixel_on,
  output logic [23:0] girl_color
);

  localparam int CNT_W = $clog2(ANIM_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);
`ifdef GIRL_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RA   = 3'd1,
    S_RB   = 3'd2,
    S_LA   = 3'd3,
    S_LB   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_facing_left;
  logic             r_sync1, r_sync2, r_sync3;
  logic             w_tick;

  assign w_tick = r_sync2 & ~r_sync3;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Walk FSM; frame_sel is loaded alongside the state so it stays registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_facing_left <= 1'b0;
      frame_sel     <= 3'd0;
    end else if (w_tick) begin
      if (move_right && !move_left) begin
        if (r_state == S_RA || r_state == S_RB) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_state   <= (r_state == S_RA) ? S_RB : S_RA;
            frame_sel <= (r_state == S_RA) ? S_RB : S_RA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_state       <= S_RA;
          frame_sel     <= S_RA;
          r_cnt         <= '0;
          r_facing_left <= 1'b0;
        end
      end else if (move_left && !move_right) begin
        if (r_state == S_LA || r_state == S_LB) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_state   <= (r_state == S_LA) ? S_LB : S_LA;
            frame_sel <= (r_state == S_LA) ? S_LB : S_LA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_state       <= S_LA;
          frame_sel     <= S_LA;
          r_cnt         <= '0;
          r_facing_left <= 1'b1;
        end
      end else begin
        r_state   <= S_IDLE;
        frame_sel <= S_IDLE;
        r_cnt     <= '0;
      end
    end
  end

  // 11-bit arithmetic keeps sprites near the right/bottom edge from wrapping.
  logic [10:0] w_x_end, w_y_end, w_relx, w_rely, w_addr_x;
  logic        w_hit, w_mirror;
  logic [23:0] w_sel_color;

  assign w_x_end  = {1'b0, girl_x} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, girl_y} + 11'(SPRITE_H);
  assign w_relx   = {1'b0, DrawX} - {1'b0, girl_x};
  assign w_rely   = {1'b0, DrawY} - {1'b0, girl_y};
  assign w_hit    = (DrawX >= girl_x) && ({1'b0, DrawX} < w_x_end) &&
                    (DrawY >= girl_y) && ({1'b0, DrawY} < w_y_end);
  assign w_mirror = MIRROR_EN && (r_state == S_IDLE) && r_facing_left;
  assign w_addr_x = w_mirror ? (11'(SPRITE_W - 1) - w_relx) : w_relx;

  assign rom_address = w_hit ? (w_rely * 11'(SPRITE_W) + w_addr_x) : 11'd0;

  always_comb begin
    w_sel_color = color_idle;
    case (r_state)
      S_RA:    w_sel_color = color_m1a;
      S_RB:    w_sel_color = color_m1b;
      S_LA:    w_sel_color = color_m2a;
      S_LB:    w_sel_color = color_m2b;
      default: w_sel_color = color_idle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      girl_pixel_on <= 1'b0;
      girl_color    <= 24'h000000;
    end else begin
      girl_pixel_on <= w_hit && (w_sel_color != TRANSPARENT);
      girl_color    <= w_hit ? w_sel_color : 24'h000000;
    end
  end

endmodule
